// File: rtl/lsu_pkg.sv
// Shared constants for the load-store unit: access-size encodings, the
// address map and a byte-merge helper used by the I/O registers.
package lsu_pkg;

  localparam int          DMEM_ADDR_W_DEF = 13;
  localparam int          SYNC_STAGES_DEF = 2;

  localparam logic [3:0]  SZ_BYTE = 4'b0001;
  localparam logic [3:0]  SZ_HALF = 4'b0011;
  localparam logic [3:0]  SZ_WORD = 4'b1111;

  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
  localparam logic [31:0] LEDR_ADDR = 32'h0000_7000;
  localparam logic [31:0] LEDG_ADDR = 32'h0000_7010;
  localparam logic [31:0] HEX_ADDR  = 32'h0000_7020;
  localparam logic [31:0] LCD_ADDR  = 32'h0000_7030;
  localparam logic [31:0] SW_ADDR   = 32'h0000_7800;
  localparam logic [31:0] BTN_ADDR  = 32'h0000_7810;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: one byte-wide array per lane, synchronous byte-strobed write,
// asynchronous read of the addressed word.
module lsu_dmem #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk_i)
      if (we_i && be_i[b]) r_lane[addr_i] <= wdata_i[8*b +: 8];

    assign rdata_o[8*b +: 8] = r_lane[addr_i];
  end

endmodule

// File: rtl/lsu.sv
// RV32I load-store unit: address decode, lane alignment, load extension,
// memory-mapped I/O registers and input synchronizers around the data memory.
module lsu #(
  parameter int          DMEM_ADDR_W = 13,
  parameter logic [31:0] DMEM_BASE   = lsu_pkg::DMEM_BASE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      st_data_i,
  input  logic             st_en_i,
  input  logic             ld_unsigned_i,
  input  logic [3:0]       size_i,
  input  logic [31:0]      io_sw_i,
  input  logic [3:0]       io_btn_i,
  output logic [31:0]      ld_data_o,
  output logic             misalign_o,
  output logic [31:0]      io_ledr_o,
  output logic [31:0]      io_ledg_o,
  output logic [7:0][6:0]  io_hex_o,
  output logic [31:0]      io_lcd_o
);

  import lsu_pkg::*;

  logic [1:0]  w_off;
  logic        w_sz_ok, w_mis, w_acc, w_we;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_is_dmem, w_is_ledr, w_is_ledg, w_is_hex, w_is_lcd, w_is_sw, w_is_btn;
  logic [31:0] w_dm_rdata, w_hex_word, w_rword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic [31:0]                   r_ledr, r_ledg, r_lcd;
  logic [7:0][6:0]               r_hex;
  logic [SYNC_STAGES-1:0][31:0]  r_sw_sync;
  logic [SYNC_STAGES-1:0][3:0]   r_btn_sync;

  assign w_off   = addr_i[1:0];
  assign w_sz_ok = (size_i == SZ_BYTE) || (size_i == SZ_HALF) || (size_i == SZ_WORD);
  assign w_mis   = ((size_i == SZ_HALF) && w_off[0]) ||
                   ((size_i == SZ_WORD) && (w_off != 2'b00));
  assign misalign_o = w_sz_ok && w_mis;
  assign w_acc   = w_sz_ok && !w_mis;
  assign w_strb  = size_i << w_off;
  assign w_wdata = st_data_i << {w_off, 3'b000};
  // Reset also blocks DMEM writes, so a store racing reset is lost everywhere.
  assign w_we    = st_en_i && w_acc && rst_ni;

  assign w_is_dmem = addr_i[31:DMEM_ADDR_W] == DMEM_BASE[31:DMEM_ADDR_W];
  assign w_is_ledr = addr_i[31:4] == LEDR_ADDR[31:4];
  assign w_is_ledg = addr_i[31:4] == LEDG_ADDR[31:4];
  assign w_is_hex  = addr_i[31:3] == HEX_ADDR[31:3];
  assign w_is_lcd  = addr_i[31:4] == LCD_ADDR[31:4];
  assign w_is_sw   = addr_i[31:4] == SW_ADDR[31:4];
  assign w_is_btn  = addr_i[31:4] == BTN_ADDR[31:4];

  lsu_dmem #(.AW(DMEM_ADDR_W-2)) u_dmem (
    .clk_i   (clk_i),
    .we_i    (w_we && w_is_dmem),
    .be_i    (w_strb),
    .addr_i  (addr_i[DMEM_ADDR_W-1:2]),
    .wdata_i (w_wdata),
    .rdata_o (w_dm_rdata)
  );

  // addr[2] picks hex4..7 vs hex0..3; each digit occupies the low 7 bits of a byte.
  assign w_hex_word = addr_i[2]
    ? {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]}
    : {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};

  always_comb begin
    w_rword = '0;
    if      (w_is_dmem) w_rword = w_dm_rdata;
    else if (w_is_ledr) w_rword = r_ledr;
    else if (w_is_ledg) w_rword = r_ledg;
    else if (w_is_hex)  w_rword = w_hex_word;
    else if (w_is_lcd)  w_rword = r_lcd;
    else if (w_is_sw)   w_rword = r_sw_sync[SYNC_STAGES-1];
    else if (w_is_btn)  w_rword = {28'b0, r_btn_sync[SYNC_STAGES-1]};
  end

  always_comb begin
    w_byte = w_rword[7:0];
    case (w_off)
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      2'd3:    w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
  end

  assign w_half = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    ld_data_o = '0;
    if (w_acc) begin
      case (size_i)
        SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        SZ_HALF: ld_data_o = ld_unsigned_i ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        SZ_WORD: ld_data_o = w_rword;
        default: ld_data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
      r_hex  <= '0;
    end else if (w_we) begin
      if (w_is_ledr) r_ledr <= merge_bytes(r_ledr, w_wdata, w_strb);
      if (w_is_ledg) r_ledg <= merge_bytes(r_ledg, w_wdata, w_strb);
      if (w_is_lcd)  r_lcd  <= merge_bytes(r_lcd,  w_wdata, w_strb);
      if (w_is_hex)
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) r_hex[{addr_i[2], b[1:0]}] <= w_wdata[8*b +: 7];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sw_sync  <= '0;
      r_btn_sync <= '0;
    end else begin
      r_sw_sync[0]  <= io_sw_i;
      r_btn_sync[0] <= io_btn_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]  <= r_sw_sync[s-1];
        r_btn_sync[s] <= r_btn_sync[s-1];
      end
    end
  end

  assign io_ledr_o = r_ledr;
  assign io_ledg_o = r_ledg;
  assign io_hex_o  = r_hex;
  assign io_lcd_o  = r_lcd;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a vector table of loads/stores checked through a scoreboard
// queue, followed by hand-written reset, I/O and synchronizer sequences.
module tb_lsu;

  localparam logic [3:0] B = 4'b0001, H = 4'b0011, W = 4'b1111;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [31:0]      addr_i, st_data_i, io_sw_i;
  logic             st_en_i, ld_unsigned_i;
  logic [3:0]       size_i, io_btn_i;
  logic [31:0]      ld_data_o, io_ledr_o, io_ledg_o, io_lcd_o;
  logic             misalign_o;
  logic [7:0][6:0]  io_hex_o;

  lsu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .st_data_i(st_data_i),
    .st_en_i(st_en_i), .ld_unsigned_i(ld_unsigned_i), .size_i(size_i),
    .io_sw_i(io_sw_i), .io_btn_i(io_btn_i), .ld_data_o(ld_data_o),
    .misalign_o(misalign_o), .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o),
    .io_hex_o(io_hex_o), .io_lcd_o(io_lcd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr, sd;
    logic        st, uns;
    logic [3:0]  sz;
    logic        chk;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  typedef struct {
    string       nm;
    logic        chk;
    logic [31:0] ld;
    logic        mis;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks = 0, failures = 0;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] sd, logic st, logic uns,
                              logic [3:0] sz, logic chk, logic [31:0] ld, logic mis);
    vec_t v;
    v.addr = a; v.sd = sd; v.st = st; v.uns = uns; v.sz = sz;
    v.chk = chk; v.ld = ld; v.mis = mis;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] sd, logic st, logic uns, logic [3:0] sz);
    addr_i = a; st_data_i = sd; st_en_i = st; ld_unsigned_i = uns; size_i = sz;
  endtask

  // Compare whatever the DUT currently presents against the oldest expectation.
  task automatic pop_check();
    exp_t e;
    e = sbq.pop_front();
    if (e.chk) cmp({e.nm, ".ld"}, ld_data_o, e.ld);
    cmp({e.nm, ".mis"}, {31'b0, misalign_o}, {31'b0, e.mis});
  endtask

  task automatic expect_ld(string nm, logic [31:0] a, logic [31:0] ld);
    drive(a, 32'h0, 1'b0, 1'b0, W);
    #1;
    sbq.push_back('{nm, 1'b1, ld, 1'b0});
    pop_check();
  endtask

  initial begin
    rst_ni = 1'b0; io_sw_i = '0; io_btn_i = '0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 4'b0000);

    // addr, st_data, st, uns, size, chk, expected ld, expected misalign
    tbl.push_back(mk(32'h2004, 32'hDEADBEEF, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h2000, 32'h11111111, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h2008, 32'h00000000, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, W, 1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(32'h2007, 32'h0,        0, 0, B, 1, 32'hFFFFFFDE, 0));
    tbl.push_back(mk(32'h2007, 32'h0,        0, 1, B, 1, 32'h000000DE, 0));
    tbl.push_back(mk(32'h2006, 32'h0,        0, 0, H, 1, 32'hFFFFDEAD, 0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 1, H, 1, 32'h0000BEEF, 0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, B, 1, 32'hFFFFFFEF, 0));
    tbl.push_back(mk(32'h2005, 32'h0,        0, 1, B, 1, 32'h000000BE, 0));
    tbl.push_back(mk(32'h2005, 32'h00000055, 1, 0, B, 1, 32'hFFFFFFBE, 0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, W, 1, 32'hDEAD55EF, 0));
    tbl.push_back(mk(32'h2006, 32'h00001234, 1, 0, H, 1, 32'hFFFFDEAD, 0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, W, 1, 32'h123455EF, 0));
    tbl.push_back(mk(32'h2006, 32'hFFFFFFFF, 1, 0, W, 1, 32'h0,        1));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, W, 1, 32'h123455EF, 0));
    tbl.push_back(mk(32'h2005, 32'h0,        0, 0, W, 1, 32'h0,        1));
    tbl.push_back(mk(32'h2005, 32'hFFFFFFFF, 1, 0, H, 1, 32'h0,        1));
    tbl.push_back(mk(32'h2004, 32'hFFFFFFFF, 1, 0, 4'b0111, 1, 32'h0,  0));
    tbl.push_back(mk(32'h2004, 32'hFFFFFFFF, 1, 0, 4'b0000, 1, 32'h0,  0));
    tbl.push_back(mk(32'h2004, 32'hFFFFFFFF, 0, 0, W, 1, 32'h123455EF, 0));
    tbl.push_back(mk(32'h2004, 32'h0,        0, 0, W, 1, 32'h123455EF, 0));
    tbl.push_back(mk(32'h3FFC, 32'hCAFE0001, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h3FFC, 32'h0,        0, 0, W, 1, 32'hCAFE0001, 0));
    tbl.push_back(mk(32'h4000, 32'h00000BAD, 1, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h4000, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h2000, 32'h0,        0, 0, W, 1, 32'h11111111, 0));
    tbl.push_back(mk(32'h1FFC, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7000, 32'h000000A5, 1, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7000, 32'h0,        0, 0, W, 1, 32'h000000A5, 0));
    tbl.push_back(mk(32'h7023, 32'h0000003F, 1, 1, B, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7020, 32'h0,        0, 0, W, 1, 32'h3F000000, 0));
    tbl.push_back(mk(32'h7021, 32'h000000FF, 1, 1, B, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7020, 32'h0,        0, 0, W, 1, 32'h3F007F00, 0));
    tbl.push_back(mk(32'h7024, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7023, 32'h0,        0, 1, B, 1, 32'h0000003F, 0));
    tbl.push_back(mk(32'h7010, 32'h00000012, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h7010, 32'h0,        0, 0, W, 1, 32'h00000012, 0));
    tbl.push_back(mk(32'h7030, 32'hCAFEF00D, 1, 0, W, 0, 32'h0,        0));
    tbl.push_back(mk(32'h7030, 32'h0,        0, 0, W, 1, 32'hCAFEF00D, 0));
    tbl.push_back(mk(32'h7032, 32'h0,        0, 0, H, 1, 32'hFFFFCAFE, 0));
    tbl.push_back(mk(32'h7800, 32'hFFFFFFFF, 1, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7800, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7810, 32'hFFFFFFFF, 1, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7810, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h5000, 32'h00001234, 1, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h5000, 32'h0,        0, 0, W, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7002, 32'h0000BEEF, 1, 0, H, 1, 32'h0,        0));
    tbl.push_back(mk(32'h7000, 32'h0,        0, 0, W, 1, 32'hBEEF00A5, 0));

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    cmp("rst.ledr", io_ledr_o, 32'h0);
    cmp("rst.ledg", io_ledg_o, 32'h0);
    cmp("rst.lcd",  io_lcd_o,  32'h0);
    for (int i = 0; i < 8; i++) cmp($sformatf("rst.hex%0d", i), {25'b0, io_hex_o[i]}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i].addr, tbl[i].sd, tbl[i].st, tbl[i].uns, tbl[i].sz);
      #1;
      sbq.push_back('{$sformatf("vec%0d", i), tbl[i].chk, tbl[i].ld, tbl[i].mis});
      pop_check();
    end

    // I/O register outputs after the table's stores
    @(negedge clk_i);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 4'b0000);
    #1;
    cmp("io.ledr", io_ledr_o, 32'hBEEF00A5);
    cmp("io.ledg", io_ledg_o, 32'h00000012);
    cmp("io.lcd",  io_lcd_o,  32'hCAFEF00D);
    cmp("io.hex3", {25'b0, io_hex_o[3]}, 32'h3F);
    cmp("io.hex1", {25'b0, io_hex_o[1]}, 32'h7F);
    cmp("io.hex0", {25'b0, io_hex_o[0]}, 32'h0);
    cmp("io.hex2", {25'b0, io_hex_o[2]}, 32'h0);

    // Stores issued while reset is asserted are dropped
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(32'h7000, 32'hFFFFFFFF, 1'b1, 1'b0, W);
    @(negedge clk_i);
    drive(32'h2008, 32'h00000077, 1'b1, 1'b0, W);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(32'h2008, 32'h0, 1'b0, 1'b0, W);
    #1;
    cmp("rst2.ledr", io_ledr_o, 32'h0);
    cmp("rst2.ledg", io_ledg_o, 32'h0);
    cmp("rst2.lcd",  io_lcd_o,  32'h0);
    cmp("rst2.hex3", {25'b0, io_hex_o[3]}, 32'h0);
    cmp("rst2.dmem", ld_data_o, 32'h0);

    // Switch synchronizer: change in cycle n visible from cycle n+2
    @(negedge clk_i);
    io_sw_i = 32'h0000F00D;
    expect_ld("sw.n",   32'h7800, 32'h0);
    @(negedge clk_i);
    expect_ld("sw.n1",  32'h7800, 32'h0);
    @(negedge clk_i);
    expect_ld("sw.n2",  32'h7800, 32'h0000F00D);
    @(negedge clk_i);
    io_btn_i = 4'hA;
    expect_ld("btn.n",  32'h7810, 32'h0);
    @(negedge clk_i);
    expect_ld("btn.n1", 32'h7810, 32'h0);
    @(negedge clk_i);
    expect_ld("btn.n2", 32'h7810, 32'h0000000A);
    @(negedge clk_i);
    expect_ld("unmapped", 32'h5000, 32'h0);

    // Reset clears the synchronizer flops too
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    expect_ld("sync.rst", 32'h7800, 32'h0);
    @(negedge clk_i);
    expect_ld("sync.rst1", 32'h7800, 32'h0);
    @(negedge clk_i);
    expect_ld("sync.rst2", 32'h7800, 32'h0000F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load-store unit of the RV32I single-cycle core, directly downstream of the control unit.
- Consumes the control unit's memory controls (mem_wren, mem_us, mem_wrnum) together with the ALU address and rs2 data.
- Owns the 8 KiB data memory and the memory-mapped I/O registers (LEDs, 7-seg, LCD, switches, buttons).
- Returns load data to the write-back mux.

Parameters:
- DMEM_ADDR_W, 13, byte-address width of data memory (8 KiB).
- DMEM_BASE, 32'h0000_2000, data memory base address.
- SYNC_STAGES, 2, synchronizer depth for switch and button inputs.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- addr_i  in  32  byte address from ALU
- st_data_i  in  32  store data (rs2)
- st_en_i  in  1  store enable (mem_wren)
- ld_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend (mem_us)
- size_i  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word (mem_wrnum)
- io_sw_i  in  32  raw switches (asynchronous)
- io_btn_i  in  4  raw buttons (asynchronous)
- ld_data_o  out  32  extended load data
- misalign_o  out  1  current access is misaligned
- io_ledr_o  out  32  red LED register
- io_ledg_o  out  32  green LED register
- io_hex_o  out  8x7  seven-segment registers hex0..hex7
- io_lcd_o  out  32  LCD register

Behaviour:
- Reset and clocking: one clock, clk_i. Reset rst_ni is synchronous and active-low.
  - On reset, ledr, ledg, all hex, lcd and synchronizer flops clear to 0.
  - Data memory contents are not reset.
- Memory map (word-decoded on addr_i[31:4] unless stated):
  - 0x2000-0x3FFF: DMEM, read/write.
  - 0x7000: ledr, R/W.
  - 0x7010: ledg, R/W.
  - 0x7020-0x7027: hex0..hex7. One byte each, bits [6:0] used, R/W.
  - 0x7030: lcd, R/W.
  - 0x7800: sw, read-only.
  - 0x7810: btn, read-only (zero-extended).
  - Unmapped addresses: reads return 0; writes are ignored.
- Alignment:
  - Half access is misaligned when addr[0]=1.
  - Word access is misaligned when addr[1:0]!=0.
  - misalign_o is combinational.
  - A misaligned access suppresses the store and forces ld_data_o=0.
  - size_i values other than 0001/0011/1111 are treated as no access: no store, ld_data_o=0, misalign_o=0.
- Store:
  - Lane strobe = size_i << addr[1:0]; data = st_data_i << (8*addr[1:0]).
  - Only strobed bytes of the target word/register update, on the rising clk_i edge when st_en_i=1 and rst_ni=1.
  - Latency: the written value is visible to a load in the next cycle.
  - Stores to sw/btn are ignored.
  - Stores to the hex window: each strobed byte writes the corresponding hexN register, bits [6:0] of that byte.
- Load:
  - Combinational, zero-cycle read of the addressed word.
  - Byte/half extracted at offset addr[1:0].
  - Extended per ld_unsigned_i: sign-extended from bit 7 (byte) or bit 15 (half) when 0; zero-extended when 1.
  - ld_data_o is driven regardless of st_en_i. A same-cycle store does not affect the returned value; the old data is returned.
- Inputs:
  - io_sw_i and io_btn_i pass through SYNC_STAGES flops before being readable.
  - Latency: a change on a raw input appears in loads SYNC_STAGES cycles later.
- Reset mid-operation:
  - A store in a cycle with rst_ni=0 is dropped for I/O registers, which take reset values.
  - A DMEM store in that cycle is also dropped.
- I/O outputs:
  - All I/O outputs are direct register outputs, with no combinational path from addr_i.

Decomposition:
- Shared package (alongside the existing Parameter definitions) holds:
  - the access-size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the address-map constants (DMEM_BASE, LEDR_ADDR, LEDG_ADDR, HEX_ADDR, LCD_ADDR, SW_ADDR, BTN_ADDR).
- One natural sub-module, dmem: byte-strobed synchronous-write, asynchronous-read RAM of 2^(DMEM_ADDR_W-2) x 32.
- Address decode, lane alignment, extension and I/O registers stay in lsu.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x2004, then lw @0x2004 -> ld_data_o=0xDEADBEEF, misalign_o=0.
- Byte load extension, memory word 0xDEADBEEF @0x2004:
  - lb @0x2007 -> 0xFFFFFFDE.
  - lbu @0x2007 -> 0x000000DE.
  - lh @0x2006 -> 0xFFFFDEAD.
  - lhu @0x2004 -> 0x0000BEEF.
- Partial stores: sb 0x55 @0x2005, then lw @0x2004 -> 0xDEAD55EF; sh 0x1234 @0x2006 -> 0x123455EF.
- Misalignment: sw 0xFFFFFFFF @0x2006 -> misalign_o=1, word @0x2004 unchanged; lw @0x2005 -> ld_data_o=0.
- I/O store and reset:
  - sw 0x000000A5 @0x7000 -> io_ledr_o=0xA5 after the edge.
  - sb 0x3F @0x7023 -> hex3=7'h3F, other hex unchanged.
  - Assert rst_ni=0 for one cycle -> all I/O outputs 0.
- Switch sync: set io_sw_i=0x0000F00D at cycle n -> lw @0x7800 returns the old value through cycle n+1 and 0x0000F00D from cycle n+2; unmapped lw @0x5000 -> 0.
